immediate_extender_pipe: RTL and testbench
==========================================

Name: immediate_extender_pipe

Overview:
- Decode-stage immediate generator with a 2-entry valid/ready skid buffer.
- Widens an IMM_WIDTH immediate to DATA_WIDTH in one of four modes: zero-extend, sign-extend, upper-load, branch offset.
- Registers the result with a tag so decode back-pressure and flushes never corrupt or reorder immediates.
- Sits between instruction decode and the ID/EX register.

Parameters:
- IMM_WIDTH, 16, width of raw immediate field.
- DATA_WIDTH, 32, width of extended result; must be >= IMM_WIDTH+2.
- TAG_WIDTH, 5, width of opaque sideband tag carried alongside the result (e.g. destination register).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  input  1  immediate/mode/tag presented.
- in_ready  output  1  block can accept this cycle.
- in_immediate  input  IMM_WIDTH  raw immediate.
- in_mode  input  2  0=ZERO, 1=SIGN, 2=UPPER, 3=BRANCH.
- in_tag  input  TAG_WIDTH  sideband passed through unchanged.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head this cycle.
- out_value  output  DATA_WIDTH  extended immediate of head entry.
- out_tag  output  TAG_WIDTH  tag of head entry.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high.
- Extension, combinational at input, latched on accept:
  - ZERO: upper bits 0.
  - SIGN: replicate in_immediate[IMM_WIDTH-1].
  - UPPER: immediate in bits [DATA_WIDTH-1 : DATA_WIDTH-IMM_WIDTH], lower bits 0.
  - BRANCH: sign-extend, then shift left 2; the top two sign bits are dropped.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2) && !flush; it does not depend on out_ready.
- Latency: an accepted item is visible on out_* the next cycle, with 1/cycle throughput when out_ready is held high.
- State machine (count of entries):
  - EMPTY: push -> ONE; otherwise stay.
  - ONE: push and pop -> ONE (new item becomes head next cycle); push only -> FULL; pop only -> EMPTY.
  - FULL: pop -> ONE (second entry promoted to head); no push possible.
- Ordering: strict FIFO; out_value and out_tag always belong to the same entry.
- Outputs when empty: out_valid=0, out_value=0, out_tag=0; stale data is never exposed.
- Flush:
  - Next state EMPTY, with both entries cleared to 0.
  - A same-cycle in_valid is not accepted (in_ready=0).
  - A same-cycle pop by the consumer is still considered completed.
- Reset: asserting reset at any time, including mid-transfer, immediately forces:
  - count=EMPTY, out_valid=0, out_value=0, out_tag=0;
  - in_ready=0 while reset is high, and 1 from the first edge after release.
- Illegal parameters (DATA_WIDTH < IMM_WIDTH+2) are rejected at elaboration.

Decomposition:
- Shared header extension_defs holds the mode encodings EXT_ZERO=0, EXT_SIGN=1, EXT_UPPER=2, EXT_BRANCH=3 and the MODE_WIDTH=2 constant. It is used by the control unit as well.
- One natural sub-module: immediate_extend_core. It is purely combinational, takes (IMM_WIDTH, DATA_WIDTH, immediate, mode) and returns value.
- immediate_extender_pipe holds the 2-entry buffer, count FSM and handshakes.

Test Plan:
- Modes, defaults, out_ready=1, in_immediate=16'h8001:
  - ZERO -> 32'h00008001;
  - SIGN -> 32'hFFFF8001;
  - UPPER -> 32'h80010000;
  - BRANCH -> 32'hFFFE0004;
  - each result appears exactly 1 cycle after accept.
- Streaming: push tags 1,2,3 on consecutive cycles with out_ready=1 -> out_valid on cycles 1..3, tags 1,2,3 in order, in_ready constantly 1.
- Back-pressure: out_ready=0, in_valid held with items A,B,C:
  - A and B are accepted and in_ready drops to 0; C is held;
  - raising out_ready drains A,B,C in order with no duplication.
- Flush:
  - assert flush in FULL with in_valid=1 -> next cycle out_valid=0, out_value=0, in_ready=1, and the input item was not accepted;
  - flush in EMPTY -> no change.
- Async reset: assert reset between edges while in ONE -> out_valid and out_value go to 0 without waiting for an edge; after release the first push behaves per the streaming scenario.
- Parametrised: IMM_WIDTH=12, DATA_WIDTH=32, immediate 12'h800:
  - SIGN -> 32'hFFFFF800;
  - UPPER -> 32'h80000000;
  - BRANCH -> 32'hFFFFE000.

Source files
------------

// File: rtl/immediate_extender_pipe_pkg.sv
// Shared definitions for the immediate extender: mode encodings and buffer occupancy states.
package immediate_extender_pipe_pkg;

  localparam int unsigned MODE_WIDTH = 2;

  localparam logic [MODE_WIDTH-1:0] EXT_ZERO   = 2'd0;
  localparam logic [MODE_WIDTH-1:0] EXT_SIGN   = 2'd1;
  localparam logic [MODE_WIDTH-1:0] EXT_UPPER  = 2'd2;
  localparam logic [MODE_WIDTH-1:0] EXT_BRANCH = 2'd3;

  // Occupancy of the 2-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } count_state_e;

endpackage

// File: rtl/immediate_extender_pipe_if.sv
// Decode-side producer channel, consumer channel and flush for the immediate extender.
interface immediate_extender_pipe_if
  import immediate_extender_pipe_pkg::*;
#(
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [IMM_WIDTH-1:0]  in_immediate;
  logic [MODE_WIDTH-1:0] in_mode;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_value;
  logic [TAG_WIDTH-1:0]  out_tag;

  // Environment side: decode producer plus ID/EX consumer
  modport master (
    output flush, in_valid, in_immediate, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_value, out_tag
  );

  modport slave (
    input  flush, in_valid, in_immediate, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_value, out_tag
  );
endinterface

// File: rtl/immediate_extender_pipe_extend_core.sv
// Combinational widening of a raw immediate according to the extension mode.
module immediate_extend_core
  import immediate_extender_pipe_pkg::*;
#(
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [IMM_WIDTH-1:0]  immediate,
  input  logic [MODE_WIDTH-1:0] mode,
  output logic [DATA_WIDTH-1:0] value
);
  localparam int unsigned PAD_WIDTH = DATA_WIDTH - IMM_WIDTH;

  logic [DATA_WIDTH-1:0] zext_c;
  logic [DATA_WIDTH-1:0] sext_c;
  logic [DATA_WIDTH-1:0] upper_c;
  logic [DATA_WIDTH-1:0] branch_c;

  assign zext_c   = {{PAD_WIDTH{1'b0}}, immediate};
  assign sext_c   = {{PAD_WIDTH{immediate[IMM_WIDTH-1]}}, immediate};
  assign upper_c  = {immediate, {PAD_WIDTH{1'b0}}};
  // Word offset to byte offset; the two topmost sign copies fall off
  assign branch_c = {sext_c[DATA_WIDTH-3:0], 2'b00};

  always_comb begin
    value = zext_c;
    case (mode)
      EXT_ZERO:   value = zext_c;
      EXT_SIGN:   value = sext_c;
      EXT_UPPER:  value = upper_c;
      EXT_BRANCH: value = branch_c;
      default:    value = zext_c;
    endcase
  end
endmodule

// File: rtl/immediate_extender_pipe.sv
// Decode-stage immediate generator: extends on accept and buffers up to two tagged results
// in strict FIFO order ahead of the ID/EX register.
module immediate_extender_pipe
  import immediate_extender_pipe_pkg::*;
#(
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  immediate_extender_pipe_if.slave   bus
);
  if (DATA_WIDTH < IMM_WIDTH + 2) begin : g_bad_params
    $error("immediate_extender_pipe: DATA_WIDTH must be >= IMM_WIDTH+2");
  end

  count_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] head_val_q, head_val_d;
  logic [TAG_WIDTH-1:0]  head_tag_q, head_tag_d;
  logic [DATA_WIDTH-1:0] tail_val_q, tail_val_d;
  logic [TAG_WIDTH-1:0]  tail_tag_q, tail_tag_d;
  logic                  rdy_en_q, rdy_en_d;

  logic [DATA_WIDTH-1:0] ext_val_c;
  logic                  in_ready_c;
  logic                  push_c;
  logic                  pop_c;

  immediate_extend_core #(
    .IMM_WIDTH  (IMM_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_extend (
    .immediate (bus.in_immediate),
    .mode      (bus.in_mode),
    .value     (ext_val_c)
  );

  // rdy_en_q holds intake off until the first edge after reset release
  assign in_ready_c = rdy_en_q && (state_q != ST_FULL) && !bus.flush;
  assign push_c     = bus.in_valid && in_ready_c;
  assign pop_c      = (state_q != ST_EMPTY) && bus.out_ready;
  assign rdy_en_d   = 1'b1;

  always_comb begin
    state_d    = state_q;
    head_val_d = head_val_q;
    head_tag_d = head_tag_q;
    tail_val_d = tail_val_q;
    tail_tag_d = tail_tag_q;

    if (bus.flush) begin
      state_d    = ST_EMPTY;
      head_val_d = '0;
      head_tag_d = '0;
      tail_val_d = '0;
      tail_tag_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_c) begin
            state_d    = ST_ONE;
            head_val_d = ext_val_c;
            head_tag_d = bus.in_tag;
          end
        end
        ST_ONE: begin
          if (push_c && pop_c) begin
            head_val_d = ext_val_c;
            head_tag_d = bus.in_tag;
          end else if (push_c) begin
            state_d    = ST_FULL;
            tail_val_d = ext_val_c;
            tail_tag_d = bus.in_tag;
          end else if (pop_c) begin
            state_d    = ST_EMPTY;
            head_val_d = '0;
            head_tag_d = '0;
          end
        end
        ST_FULL: begin
          if (pop_c) begin
            state_d    = ST_ONE;
            head_val_d = tail_val_q;
            head_tag_d = tail_tag_q;
            tail_val_d = '0;
            tail_tag_d = '0;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          head_val_d = '0;
          head_tag_d = '0;
          tail_val_d = '0;
          tail_tag_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      head_val_q <= '0;
      head_tag_q <= '0;
      tail_val_q <= '0;
      tail_tag_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_val_q <= head_val_d;
      head_tag_q <= head_tag_d;
      tail_val_q <= tail_val_d;
      tail_tag_q <= tail_tag_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

  // Head storage is cleared whenever it is vacated, so empty reads back as zero
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_value = head_val_q;
  assign bus.out_tag   = head_tag_q;
endmodule

// File: tb/tb_immediate_extender_pipe.sv
// Self-checking bench for immediate_extender_pipe against a queue-based reference model.
module tb_immediate_extender_pipe;
  logic clk;
  logic reset;

  immediate_extender_pipe_if #(.IMM_WIDTH(16), .DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();
  immediate_extender_pipe_if #(.IMM_WIDTH(12), .DATA_WIDTH(32), .TAG_WIDTH(5)) bus2 ();

  immediate_extender_pipe #(.IMM_WIDTH(16), .DATA_WIDTH(32), .TAG_WIDTH(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  immediate_extender_pipe #(.IMM_WIDTH(12), .DATA_WIDTH(32), .TAG_WIDTH(5)) u_dut12 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint val;
    int     tag;
  } entry_t;

  entry_t q[$];
  bit     rdy_en_m;
  int     n_tests;
  int     n_fail;
  longint obs_val;
  bit     obs_rdy;
  bit     obs_vld;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference extension from the arithmetic meaning of each mode
  function automatic longint ref_ext(input int iw, input int dw, input longint imm, input int mode);
    longint mask;
    longint s;
    mask = (64'sd1 <<< dw) - 1;
    s    = (imm >= (64'sd1 <<< (iw - 1))) ? imm - (64'sd1 <<< iw) : imm;
    case (mode)
      0:       return imm;
      1:       return s & mask;
      2:       return (imm <<< (dw - iw)) & mask;
      default: return (s * 4) & mask;
    endcase
  endfunction

  // One clock cycle: drive, compare at negedge, advance the model at posedge
  task automatic step(input bit v, input int imm, input int mode, input int tag,
                      input bit ordy, input bit fl, output bit acc);
    bit     pop;
    bit     exp_rdy;
    longint exp_val;
    int     exp_tag;
    bus.in_valid     = v;
    bus.in_immediate = 16'(imm);
    bus.in_mode      = 2'(mode);
    bus.in_tag       = 5'(tag);
    bus.out_ready    = ordy;
    bus.flush        = fl;
    @(negedge clk);
    exp_rdy = rdy_en_m && (q.size() != 2) && !fl;
    exp_val = (q.size() != 0) ? q[0].val : 0;
    exp_tag = (q.size() != 0) ? q[0].tag : 0;
    obs_val = longint'(bus.out_value);
    obs_rdy = bus.in_ready;
    obs_vld = bus.out_valid;
    check("out_valid", longint'(bus.out_valid), longint'(q.size() != 0));
    check("out_value", longint'(bus.out_value), exp_val);
    check("out_tag",   longint'(bus.out_tag),   longint'(exp_tag));
    check("in_ready",  longint'(bus.in_ready),  longint'(exp_rdy));
    acc = v && exp_rdy;
    pop = (q.size() != 0) && ordy;
    @(posedge clk);
    rdy_en_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) q.push_back('{val: ref_ext(16, 32, longint'(imm), mode), tag: tag});
    #1;
  endtask

  initial begin
    bit acc;
    int idx;
    int bp_imm [3];
    n_tests  = 0;
    n_fail   = 0;
    rdy_en_m = 1'b0;
    reset    = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_immediate = '0;
    bus.in_mode = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.in_immediate = '0;
    bus2.in_mode = '0; bus2.in_tag = '0; bus2.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_in_ready",  longint'(bus.in_ready),  0);
    reset = 1'b0;
    step(0, 0, 0, 0, 1, 0, acc);

    // Four modes on 16'h8001, one per cycle
    step(1, 'h8001, 0, 1, 1, 0, acc);
    step(1, 'h8001, 1, 2, 1, 0, acc);
    check("mode_zero", obs_val, 64'h0000_8001);
    step(1, 'h8001, 2, 3, 1, 0, acc);
    check("mode_sign", obs_val, 64'hFFFF_8001);
    step(1, 'h8001, 3, 4, 1, 0, acc);
    check("mode_upper", obs_val, 64'h8001_0000);
    step(0, 0, 0, 0, 1, 0, acc);
    check("mode_branch", obs_val, 64'hFFFE_0004);
    step(0, 0, 0, 0, 1, 0, acc);

    // Back-pressure: A,B accepted, C held until the consumer drains
    bp_imm[0] = 'h0123; bp_imm[1] = 'h8456; bp_imm[2] = 'h7FFF;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1, bp_imm[idx], 1, 10 + idx, 0, 0, acc);
      if (acc && idx < 2) idx++;
    end
    check("bp_accepted_two", longint'(idx), 2);
    check("bp_ready_low", longint'(obs_rdy), 0);
    for (int c = 0; c < 6 && idx < 3; c++) begin
      step(1, bp_imm[idx], 1, 10 + idx, 1, 0, acc);
      if (acc) idx++;
    end
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 1, 0, acc);
    check("bp_drained", longint'(obs_vld), 0);

    // Flush while FULL with a same-cycle input offer
    step(1, 'h1111, 0, 20, 0, 0, acc);
    step(1, 'h2222, 0, 21, 0, 0, acc);
    step(1, 'h3333, 0, 22, 0, 1, acc);
    check("flush_no_accept", longint'(acc), 0);
    step(0, 0, 0, 0, 0, 0, acc);
    check("flush_valid", longint'(obs_vld), 0);
    check("flush_value", obs_val, 0);
    check("flush_ready", longint'(obs_rdy), 1);
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 0, acc);

    // Asynchronous reset between edges while holding one entry
    step(1, 'h4242, 1, 7, 0, 0, acc);
    #2;
    check("pre_arst_valid", longint'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    check("arst_valid", longint'(bus.out_valid), 0);
    check("arst_value", longint'(bus.out_value), 0);
    check("arst_ready", longint'(bus.in_ready), 0);
    q.delete();
    rdy_en_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 0, 1, 0, acc);

    // Streaming tags 1,2,3 back to back
    for (int t = 1; t <= 3; t++) begin
      step(1, 'h0100 * t, t, t, 1, 0, acc);
      check("stream_ready", longint'(obs_rdy), 1);
    end
    step(0, 0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 0, 1, 0, acc);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(3) != 0), int'($urandom_range(16'hFFFF)), int'($urandom_range(3)),
           int'($urandom_range(31)), ($urandom_range(2) != 0), ($urandom_range(15) == 0), acc);
    end

    // 12-bit immediate instance
    for (int m = 1; m <= 3; m++) begin
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b1; bus2.in_immediate = 12'h800; bus2.in_mode = 2'(m); bus2.in_tag = 5'(m);
      @(negedge clk);
      check("w12_ready", longint'(bus2.in_ready), 1);
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      @(negedge clk);
      check("w12_model", longint'(bus2.out_value), ref_ext(12, 32, 64'h800, m));
      check("w12_tag", longint'(bus2.out_tag), longint'(m));
      case (m)
        1:       check("w12_sign",   longint'(bus2.out_value), 64'hFFFF_F800);
        2:       check("w12_upper",  longint'(bus2.out_value), 64'h8000_0000);
        default: check("w12_branch", longint'(bus2.out_value), 64'hFFFF_E000);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
